mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - Sits between the multicycle main control FSM and external memory.
// - Turns one-cycle access requests (fetch, load, store) into a mem_req/mem_ready handshake.
// - Holds the controller in its current state with stall until memory answers.
// - Owns the instruction register (IR) and the load data register (DR) that the datapath reads.
// PARAMETERS
// ADDR_W       32   memory address width
// DATA_W       32   data / instruction width
// TIMEOUT_CYC  255  max cycles in WAIT without mem_ready before abort (>=1)
// PORTS
// clk           in   1       clock, rising edge
// reset         in   1       asynchronous, active-high
// req_valid     in   1       controller needs a memory access this state
// req_we        in   1       1 = store (controller memwrite)
// req_fetch     in   1       1 = instruction fetch (controller irwrite)
// req_addr      in   ADDR_W  access address (PC or ALU result, selected by iord)
// req_wdata     in   DATA_W  store data
// stall         out  1       freeze controller state register and PC write
// instr         out  DATA_W  instruction register
// rdata         out  DATA_W  load data register
// err           out  1       sticky memory timeout flag
// mem_req       out  1       memory request
// mem_we        out  1       memory write enable
// mem_addr      out  ADDR_W  memory address
// mem_wdata     out  DATA_W  memory write data
// mem_ready     in   1       memory completes the request this cycle
// mem_rdata     in   DATA_W  read data, valid when mem_ready=1
// BEHAVIOUR
// - Reset values: state=IDLE; mem_req, mem_we, err and stall = 0; mem_addr, mem_wdata, instr, rdata = 0; timeout counter = 0.
// - FSM states: IDLE, WAIT, DONE.
// - IDLE
//   - req_valid=1: stall=1 combinationally.
//   - Captures req_addr, req_wdata, req_we and req_fetch into mem_addr, mem_wdata, mem_we and a fetch flag.
//   - Moves to WAIT.
//   - req_valid=0: stays in IDLE with stall=0.
// - WAIT
//   - mem_req=1; stall=1; mem_addr, mem_we and mem_wdata are held stable from registers.
//   - mem_ready=1 (read): fetch -> instr<=mem_rdata; otherwise rdata<=mem_rdata.
//   - mem_ready=1 (write): instr and rdata are unchanged.
//   - After mem_ready: moves to DONE; mem_req is 0 in the next cycle.
//   - Counter increments each WAIT cycle without mem_ready.
//   - Counter reaches TIMEOUT_CYC: err<=1, mem_req drops, moves to DONE, instr and rdata are unchanged.
// - DONE
//   - stall=0 for exactly one cycle, so the controller advances at this clock edge.
//   - Counter clears; moves to IDLE.
//   - req_valid is ignored in DONE: it belongs to the finished access.
// - Latency: request seen in cycle N, mem_ready in cycle N+1 at the earliest, stall low in cycle N+2.
//   - Minimum memory state length is 3 cycles; each extra wait cycle adds 1.
// - req_fetch=1 with req_we=1 is handled as a store: no IR update.
// - req_valid dropping during WAIT does not abort the access; it completes normally.
// - mem_ready while not in WAIT is ignored.
// - Any input change during WAIT is ignored: request fields were latched in IDLE.
// - err is cleared only by reset; later accesses proceed normally while err=1.
// - Reset mid-access: mem_req drops immediately (async), FSM returns to IDLE, and the pending access is lost.
// - The counter is wide enough for TIMEOUT_CYC and does not wrap.
// TESTING
// - Fetch, addr 0x10, mem_ready 1 cycle later with 0xDEADBEEF -> instr=0xDEADBEEF, rdata=0, stall high for 2 cycles then low for 1.
// - Load at 0x40, mem_ready after 5 wait cycles with 0x12345678 -> rdata=0x12345678, instr unchanged, mem_addr stable all 5 cycles.
// - Store 0xCAFEF00D at 0x80 -> mem_we=1 and mem_wdata=0xCAFEF00D while mem_req=1; instr and rdata unchanged.
// - TIMEOUT_CYC=4, mem_ready never asserted -> err=1 after 4 WAIT cycles, stall released in DONE; next access still completes.
// - Async reset asserted in WAIT -> mem_req=0 and stall=0 immediately; instr=rdata=0; err=0.
// - Back-to-back fetch then load with req_valid held high through DONE -> exactly two mem_req pulses, no duplicate access.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access unit: turns one-cycle fetch/load/store requests from the
// multicycle controller into a mem_req/mem_ready handshake, stalling the
// controller until memory answers, and owns the IR and load data register.
//
// Ports:
//   clk, reset       clock (rising edge), async active-high reset
//   req_valid        controller wants a memory access in this state
//   req_we           1 = store
//   req_fetch        1 = instruction fetch (IR write)
//   req_addr         access address
//   req_wdata        store data
//   stall            freeze controller state register / PC write
//   instr            instruction register
//   rdata            load data register
//   err              sticky memory timeout flag
//   mem_req          memory request
//   mem_we           memory write enable
//   mem_addr         memory address
//   mem_wdata        memory write data
//   mem_ready        memory completes the request this cycle
//   mem_rdata        read data, valid with mem_ready
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic              req_fetch,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LP_TMO = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_fetch;
  logic [DATA_W-1:0]  r_instr;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_err;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               w_busy;

  assign w_cnt_nxt = r_cnt + CW'(1);

  // Stall is raised in the request cycle itself so the controller holds
  // its state; reset forces it low so a reset mid-access frees the core.
  assign w_busy = (r_state == S_WAIT) ||
                  ((r_state == S_IDLE) && req_valid);
  assign stall  = w_busy && !reset;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign instr     = r_instr;
  assign rdata     = r_rdata;
  assign err       = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_fetch     <= 1'b0;
      r_instr     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_mem_addr  <= req_addr;
            r_mem_wdata <= req_wdata;
            r_mem_we    <= req_we;
            // A store with irwrite set never touches the IR.
            r_fetch     <= req_fetch && !req_we;
            r_mem_req   <= 1'b1;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            if (!r_mem_we) begin
              if (r_fetch) r_instr <= mem_rdata;
              else         r_rdata <= mem_rdata;
            end
            r_mem_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (w_cnt_nxt == LP_TMO) begin
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
            r_cnt     <= w_cnt_nxt;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_DONE: begin
          // req_valid here still belongs to the finished access.
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: fetch, load, store, back-to-back,
// async reset mid-access and memory timeout (second instance, TIMEOUT_CYC=4).
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic        req_fetch;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        t_mem_ready;

  logic        stall, err, mem_req, mem_we;
  logic [31:0] instr, rdata, mem_addr, mem_wdata;

  logic        t_stall, t_err, t_mem_req, t_mem_we;
  logic [31:0] t_instr, t_rdata, t_mem_addr, t_mem_wdata;

  int n_chk;
  int n_err;
  int pulses;
  logic prev_req;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we),
    .req_fetch(req_fetch), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall),
    .instr(instr), .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.TIMEOUT_CYC(4)) dut_t (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we),
    .req_fetch(req_fetch), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(t_stall),
    .instr(t_instr), .rdata(t_rdata), .err(t_err),
    .mem_req(t_mem_req), .mem_we(t_mem_we),
    .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_ready(t_mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req && !prev_req) pulses = pulses + 1;
    prev_req = mem_req;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic req(input logic v, input logic we,
                     input logic f, input logic [31:0] a,
                     input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    req_fetch = f;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    pulses = 0;
    prev_req = 1'b0;
    reset = 1'b1;
    mem_ready = 1'b0;
    t_mem_ready = 1'b0;
    mem_rdata = '0;
    req(1'b0, 1'b0, 1'b0, '0, '0);

    #12;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fetch at 0x10, ready one cycle later
    @(negedge clk);
    req(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    #1 chk("f_stall_n", {31'd0, stall}, 32'd1);
    @(negedge clk);
    chk("f_stall_w", {31'd0, stall}, 32'd1);
    chk("f_req_w", {31'd0, mem_req}, 32'd1);
    chk("f_addr", mem_addr, 32'h10);
    chk("f_we", {31'd0, mem_we}, 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("f_stall_d", {31'd0, stall}, 32'd0);
    chk("f_req_d", {31'd0, mem_req}, 32'd0);
    chk("f_instr", instr, 32'hDEADBEEF);
    chk("f_rdata", rdata, 32'd0);
    req_valid = 1'b0;

    // Stray mem_ready in IDLE must be ignored
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("idle_rdy_rd", rdata, 32'd0);
    chk("idle_rdy_ir", instr, 32'hDEADBEEF);

    // Load at 0x40, 5 wait cycles, inputs wiggle while waiting
    req(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("l_addr", mem_addr, 32'h40);
      chk("l_stall", {31'd0, stall}, 32'd1);
      req(1'b0, 1'b1, 1'b1, 32'hFFFF0000 + i, 32'h1);
      @(negedge clk);
    end
    chk("l_req6", {31'd0, mem_req}, 32'd1);
    chk("l_we6", {31'd0, mem_we}, 32'd0);
    req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("l_stall_d", {31'd0, stall}, 32'd0);
    chk("l_rdata", rdata, 32'h12345678);
    chk("l_instr", instr, 32'hDEADBEEF);
    @(negedge clk);

    // Store with irwrite also set: treated as a store
    req(1'b1, 1'b1, 1'b1, 32'h80, 32'hCAFEF00D);
    @(negedge clk);
    chk("s_req", {31'd0, mem_req}, 32'd1);
    chk("s_we", {31'd0, mem_we}, 32'd1);
    chk("s_wdata", mem_wdata, 32'hCAFEF00D);
    chk("s_addr", mem_addr, 32'h80);
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    mem_ready = 1'b0;
    req_valid = 1'b0;
    chk("s_instr", instr, 32'hDEADBEEF);
    chk("s_rdata", rdata, 32'h12345678);
    chk("s_stall_d", {31'd0, stall}, 32'd0);
    @(negedge clk);

    // Back-to-back fetch then load, req_valid high through DONE
    pulses = 0;
    req(1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'h11111111;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("bb_done1", {31'd0, stall}, 32'd0);
    chk("bb_req_d1", {31'd0, mem_req}, 32'd0);
    req(1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
    @(negedge clk);
    chk("bb_idle2", {31'd0, stall}, 32'd1);
    @(negedge clk);
    chk("bb_addr2", mem_addr, 32'h24);
    mem_ready = 1'b1;
    mem_rdata = 32'h22222222;
    @(negedge clk);
    mem_ready = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bb_pulses", pulses, 32'd2);
    chk("bb_instr", instr, 32'h11111111);
    chk("bb_rdata", rdata, 32'h22222222);
    chk("bb_stall", {31'd0, stall}, 32'd0);

    // Async reset while waiting
    req(1'b1, 1'b0, 1'b0, 32'h90, 32'h0);
    @(negedge clk);
    chk("r_req_w", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("r_req", {31'd0, mem_req}, 32'd0);
    chk("r_stall", {31'd0, stall}, 32'd0);
    chk("r_instr", instr, 32'd0);
    chk("r_rdata", rdata, 32'd0);
    chk("r_err", {31'd0, err}, 32'd0);
    chk("r_t_err", {31'd0, t_err}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Timeout on the TIMEOUT_CYC=4 instance
    @(negedge clk);
    req(1'b1, 1'b0, 1'b0, 32'h50, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("t_req_w", {31'd0, t_mem_req}, 32'd1);
      chk("t_err_w", {31'd0, t_err}, 32'd0);
      @(negedge clk);
    end
    chk("t_err", {31'd0, t_err}, 32'd1);
    chk("t_req_d", {31'd0, t_mem_req}, 32'd0);
    chk("t_stall_d", {31'd0, t_stall}, 32'd0);
    chk("t_rdata", t_rdata, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    req(1'b1, 1'b0, 1'b1, 32'h60, 32'h0);
    @(negedge clk);
    chk("t2_req", {31'd0, t_mem_req}, 32'd1);
    t_mem_ready = 1'b1;
    mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    t_mem_ready = 1'b0;
    req_valid = 1'b0;
    chk("t2_instr", t_instr, 32'h0BADF00D);
    chk("t2_err", {31'd0, t_err}, 32'd1);
    chk("t2_stall", {31'd0, t_stall}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
